// File: rtl/swap_sort_ctrl.sv
// Batch bubble sorter: load DEPTH words, compare-exchange one pair per clock, drain ascending.
// Optional SWAP_CNT_EN adds a saturating per-batch swap counter on swap_cnt.
module swap_sort_ctrl #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
`ifdef SWAP_CNT_EN
   ,
   output logic [7:0]       swap_cnt
`endif
);

   localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [IW:0]   J_LIM  = (IW+1)'(DEPTH - 2);
   localparam logic [IW-1:0] P_LIM  = IW'(DEPTH - 2);
   localparam logic [IW-1:0] W_LAST = IW'(DEPTH - 1);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [IW-1:0]    wr_idx;
   logic [IW-1:0]    rd_idx;
   logic [IW-1:0]    j;
   logic [IW-1:0]    j_nx;
   logic [IW-1:0]    pass;
   logic [IW:0]      jp;
   logic             swapped;
   logic             do_swap;
   logic             pass_end;
   logic             last_pass;
   logic             load_done;
   logic             sort_done;
   logic             drain_done;

   assign j_nx      = j + IW'(1);
   assign jp        = {1'b0, j} + {1'b0, pass};
   assign do_swap   = (state == SORT) && (mem[j] > mem[j_nx]);
   // pass ends once j reaches DEPTH-2-pass
   assign pass_end  = (jp >= J_LIM);
   assign last_pass = (pass == P_LIM);

   assign load_done  = (state == LOAD) && in_valid && (wr_idx == W_LAST);
   assign sort_done  = (state == SORT) && pass_end &&
                       (!(swapped || do_swap) || last_pass);
   assign drain_done = (state == DRAIN) && out_ready && (rd_idx == W_LAST);

   always_comb begin
      state_nxt = state;
      unique case (1'b1)
         load_done:  state_nxt = SORT;
         sort_done:  state_nxt = DRAIN;
         drain_done: state_nxt = LOAD;
         default:    state_nxt = state;
      endcase
   end

   assign in_ready  = (state == LOAD);
   assign out_valid = (state == DRAIN);
   assign busy      = (state == SORT);
   assign out_data  = out_valid ? mem[rd_idx] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= LOAD;
         wr_idx  <= '0;
         rd_idx  <= '0;
         j       <= '0;
         pass    <= '0;
         swapped <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            LOAD: begin
               if (in_valid) begin
                  mem[wr_idx] <= in_data;
                  if (wr_idx == W_LAST) begin
                     wr_idx  <= '0;
                     j       <= '0;
                     pass    <= '0;
                     swapped <= 1'b0;
                  end else begin
                     wr_idx <= wr_idx + IW'(1);
                  end
               end
            end
            SORT: begin
               if (do_swap) begin
                  mem[j]    <= mem[j_nx];
                  mem[j_nx] <= mem[j];
                  swapped   <= 1'b1;
               end
               if (!pass_end) begin
                  j <= j_nx;
               end else if (!sort_done) begin
                  pass    <= pass + IW'(1);
                  j       <= '0;
                  swapped <= 1'b0;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  rd_idx <= drain_done ? '0 : rd_idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SWAP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         swap_cnt <= 8'd0;
      end else if (load_done) begin
         swap_cnt <= 8'd0;
      end else if (do_swap && (swap_cnt != 8'hFF)) begin
         swap_cnt <= swap_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_swap_sort_ctrl.sv
// Self-checking bench for swap_sort_ctrl (DEPTH=4, WIDTH=4).
// Directed vector table, hold/noise/reset sequences and random batches vs a sort model.
module tb_swap_sort_ctrl;

   typedef logic [3:0] word_arr_t [4];

   typedef struct {
      word_arr_t w;
      word_arr_t e;
      int        busy;
      int        swaps;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       busy;
`ifdef SWAP_CNT_EN
   logic [7:0] swap_cnt;
`endif

   int total;
   int bad;

   swap_sort_ctrl #(.WIDTH(4), .DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
`ifdef SWAP_CNT_EN
      ,
      .swap_cnt  (swap_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   // Sorted order by value counting; swaps = inversions;
   // passes = 1 + max count of larger words ahead of any word, capped at DEPTH-1.
   function automatic void ref_model(input word_arr_t w, output word_arr_t s,
                                     output int bcy, output int sw);
      int n, g, k, p;
      n = 0;
      for (int v = 0; v < 16; v++)
         for (int i = 0; i < 4; i++)
            if (int'(w[i]) == v) begin
               s[n] = 4'(v);
               n++;
            end
      sw = 0;
      k = 0;
      for (int i = 0; i < 4; i++) begin
         g = 0;
         for (int q = 0; q < i; q++)
            if (w[q] > w[i]) g++;
         sw += g;
         if (g > k) k = g;
      end
      p = (k + 1 < 3) ? k + 1 : 3;
      bcy = 0;
      for (int q = 0; q < p; q++) bcy += 3 - q;
   endfunction

   task automatic run_batch(input word_arr_t w, input word_arr_t e,
                            input int ebusy, input int eswaps,
                            input int hold, input bit noise,
                            input string tag);
      int n, cyc, held, bcnt;
      n = 0;
      cyc = 0;
      held = 0;
      bcnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk({tag, ".in_ready_load"}, int'(in_ready), 1);
         in_valid  = 1'b1;
         in_data   = w[i];
         out_ready = 1'($urandom);
         @(posedge clk);
      end
      while (n < 4 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (busy) bcnt++;
         if (noise) begin
            in_valid = 1'($urandom);
            in_data  = 4'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid) begin
            chk({tag, ".in_ready_drain"}, int'(in_ready), 0);
            chk({tag, ".out_data"}, int'(out_data), int'(e[n]));
            if (held < hold) begin
               out_ready = 1'b0;
               held++;
            end else begin
               out_ready = 1'b1;
               n++;
            end
         end else begin
            out_ready = 1'($urandom);
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({tag, ".words"}, n, 4);
      chk({tag, ".busy_cycles"}, bcnt, ebusy);
      chk({tag, ".in_ready_after"}, int'(in_ready), 1);
      chk({tag, ".out_valid_after"}, int'(out_valid), 0);
`ifdef SWAP_CNT_EN
      chk({tag, ".swap_cnt"}, int'(swap_cnt), eswaps);
`else
      if (eswaps < 0) $display("unexpected swap count");
`endif
   endtask

   vec_t      tbl [4];
   word_arr_t w;
   word_arr_t e;
   int        eb;
   int        es;

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 4'd0;
      out_ready = 1'b0;

      tbl[0].w = '{4'd3, 4'd1, 4'd2, 4'd0};
      tbl[0].e = '{4'd0, 4'd1, 4'd2, 4'd3};
      tbl[0].busy = 6; tbl[0].swaps = 5;
      tbl[1].w = '{4'd0, 4'd1, 4'd2, 4'd3};
      tbl[1].e = '{4'd0, 4'd1, 4'd2, 4'd3};
      tbl[1].busy = 3; tbl[1].swaps = 0;
      tbl[2].w = '{4'd15, 4'd10, 4'd5, 4'd0};
      tbl[2].e = '{4'd0, 4'd5, 4'd10, 4'd15};
      tbl[2].busy = 6; tbl[2].swaps = 6;
      tbl[3].w = '{4'd1, 4'd1, 4'd0, 4'd1};
      tbl[3].e = '{4'd0, 4'd1, 4'd1, 4'd1};
      tbl[3].busy = 6; tbl[3].swaps = 2;

      #3;
      chk("rst.in_ready", int'(in_ready), 1);
      chk("rst.out_valid", int'(out_valid), 0);
      chk("rst.busy", int'(busy), 0);
      chk("rst.out_data", int'(out_data), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 4; t++)
         run_batch(tbl[t].w, tbl[t].e, tbl[t].busy, tbl[t].swaps, 0, 1'b0,
                   $sformatf("vec%0d", t));

      // consumer stalls 5 cycles while producer keeps pushing garbage
      w = '{4'd3, 4'd2, 4'd0, 4'd1};
      ref_model(w, e, eb, es);
      run_batch(w, e, eb, es, 5, 1'b1, "hold");

      // async reset mid-sort, then a clean batch
      w = '{4'd15, 4'd10, 4'd5, 4'd0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = w[i];
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("midsort.busy_before", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midsort.out_valid", int'(out_valid), 0);
      chk("midsort.busy", int'(busy), 0);
      chk("midsort.in_ready", int'(in_ready), 1);
      chk("midsort.out_data", int'(out_data), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      w = '{4'd2, 4'd0, 4'd3, 4'd1};
      ref_model(w, e, eb, es);
      run_batch(w, e, eb, es, 0, 1'b0, "post_rst");

      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < 4; i++) w[i] = 4'($urandom_range(0, 15));
         ref_model(w, e, eb, es);
         run_batch(w, e, eb, es, int'($urandom_range(0, 3)),
                   1'($urandom), $sformatf("rnd%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
